cache_fill_fsm: RTL and testbench

- Miss-handling responder for the data/instruction cache of the 16-bit pipelined CPU.
- When the cache reports a miss on a load or store access, the block fetches the whole 16-byte block from the multicycle main memory, one 16-bit word at a time.
- It writes each returned word into the cache data array and writes the tag after the last word.
- It holds fsm_busy high so the pipeline stalls until the fill completes.

---
 rtl/cache_fill_fsm.sv | 73 +++++++
 tb/tb_cache_fill_fsm.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches a missing cache block word by word from main memory, writing data then tag; stalls pipeline via fsm_busy.
// Optional macro CRITICAL_WORD_FIRST_EN: start the fill at the missing word and wrap around the block.
module cache_fill_fsm #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           miss_detected,
  input  logic [ADDR_W-1:0]              miss_address,
  input  logic                           memory_data_valid,
  input  logic [DATA_W-1:0]              memory_data_out,
  output logic                           fsm_busy,
  output logic                           mem_en,
  output logic [ADDR_W-1:0]              memory_address,
  output logic                           write_data_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_idx,
  output logic [DATA_W-1:0]              fill_data,
  output logic                           write_tag_array
);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  typedef enum logic {IDLE, FILL} state_t;
  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [OFF_W:0]    issue_q;
  logic [OFF_W:0]    recv_q;
  logic [OFF_W-1:0]  issue_ord;
  logic [OFF_W-1:0]  recv_ord;
  logic              fill;
`ifdef CRITICAL_WORD_FIRST_EN
  logic [OFF_W-1:0]  off_q;
  assign issue_ord = off_q + issue_q[OFF_W-1:0];
  assign recv_ord  = off_q + recv_q[OFF_W-1:0];
`else
  assign issue_ord = issue_q[OFF_W-1:0];
  assign recv_ord  = recv_q[OFF_W-1:0];
`endif
  assign fill             = state_q == FILL;
  assign fsm_busy         = fill;
  // issue counter MSB set means every word of the block has been requested
  assign mem_en           = fill && !issue_q[OFF_W];
  assign write_data_array = fill && memory_data_valid;
  assign write_tag_array  = write_data_array && recv_q == (OFF_W+1)'(BLOCK_WORDS - 1);
  assign memory_address   = mem_en ? base_q + ADDR_W'({issue_ord, 1'b0}) : '0;
  assign fill_word_idx    = write_data_array ? recv_ord : '0;
  assign fill_data        = memory_data_out;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      issue_q <= '0;
      recv_q  <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
      off_q   <= '0;
`endif
    end else if (!fill) begin
      if (miss_detected) begin
        state_q <= FILL;
        base_q  <= miss_address & ~ADDR_W'(2 * BLOCK_WORDS - 1);
        issue_q <= '0;
        recv_q  <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
        off_q   <= miss_address[OFF_W:1];
`endif
      end
    end else begin
      if (mem_en) issue_q <= issue_q + 1'b1;
      if (write_data_array) recv_q <= recv_q + 1'b1;
      if (write_tag_array) state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: table-driven and randomized checks of cache_fill_fsm against a queue-based memory and fill model.
module tb_cache_fill_fsm;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int BW = 8;
`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
  logic [AW-1:0] cwf_a [8] = '{16'h200A, 16'h200C, 16'h200E, 16'h2000, 16'h2002, 16'h2004, 16'h2006, 16'h2008};
  logic [2:0]    cwf_i [8] = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
`else
  localparam bit CWF = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, miss_detected = 1'b0, memory_data_valid = 1'b0;
  logic [AW-1:0] miss_address = '0;
  logic [DW-1:0] memory_data_out = '0;
  logic fsm_busy, mem_en, write_data_array, write_tag_array;
  logic [AW-1:0] memory_address;
  logic [2:0] fill_word_idx;
  logic [DW-1:0] fill_data;
  int passed = 0, total = 0;
  typedef struct {
    logic miss; logic valid; logic busy; logic en;
    logic [AW-1:0] addr; logic wr; logic [2:0] idx; logic tag;
  } vec_t;
  vec_t tv[15];
  logic m_busy = 1'b0;
  logic [AW-1:0] m_base = '0;
  int m_iss = 0, m_rcv = 0, m_off = 0, cyc = 0, lat_lo = 4, lat_hi = 4;
  bit spur = 1'b0;
  int ret_q[$];
  logic [AW-1:0] radr_q[$];
  int en_cyc[$], wr_cyc[$], tag_cyc[$];
  logic [AW-1:0] en_adr[$];
  logic [2:0] wr_idx[$];

  cache_fill_fsm dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data_valid(memory_data_valid), .memory_data_out(memory_data_out),
    .fsm_busy(fsm_busy), .mem_en(mem_en), .memory_address(memory_address),
    .write_data_array(write_data_array), .fill_word_idx(fill_word_idx),
    .fill_data(fill_data), .write_tag_array(write_tag_array)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ord(int n, int off);
    return 3'((n + (CWF ? off : 0)) % BW);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
  endtask

  task automatic clear();
    en_cyc.delete(); en_adr.delete(); wr_cyc.delete(); wr_idx.delete(); tag_cyc.delete();
    cyc = 0;
  endtask

  // One clock cycle: drive inputs, check outputs at negedge against the model, then advance the model.
  task automatic cycle(input logic mi, input logic [AW-1:0] ma, input logic ri);
    logic en_x, wr_x, tag_x;
    logic [DW-1:0] d;
    logic [AW-1:0] ra, ea;
    int r;
    rst = ri; miss_detected = mi; miss_address = ma;
    memory_data_valid = ret_q.size() > 0 && ret_q[0] == cyc;
    if (memory_data_valid) begin
      void'(ret_q.pop_front());
      ra = radr_q.pop_front();
      d = ra ^ 16'h5A3C;
    end else begin
      d = 16'($urandom);
      if (spur && !m_busy && ret_q.size() == 0 && $urandom_range(0, 3) == 0) memory_data_valid = 1'b1;
    end
    memory_data_out = d;
    @(negedge clk);
    en_x  = m_busy && m_iss < BW;
    wr_x  = m_busy && memory_data_valid;
    tag_x = wr_x && m_rcv == BW - 1;
    ea    = 16'(m_base + 16'(2 * ord(m_iss, m_off)));
    chk("busy", fsm_busy, m_busy);
    chk("mem_en", mem_en, en_x);
    chk("mem_addr", memory_address, en_x ? ea : 16'h0);
    chk("wr_data", write_data_array, wr_x);
    chk("fill_idx", fill_word_idx, wr_x ? ord(m_rcv, m_off) : 3'd0);
    chk("wr_tag", write_tag_array, tag_x);
    chk("fill_data", fill_data, d);
    if (mem_en) begin en_cyc.push_back(cyc); en_adr.push_back(memory_address); end
    if (write_data_array) begin wr_cyc.push_back(cyc); wr_idx.push_back(fill_word_idx); end
    if (write_tag_array) tag_cyc.push_back(cyc);
    if (en_x) begin
      r = cyc + int'($urandom_range(lat_lo, lat_hi));
      if (ret_q.size() > 0 && r <= ret_q[$]) r = ret_q[$] + 1;
      ret_q.push_back(r);
      radr_q.push_back(ea);
    end
    if (ri) m_busy = 1'b0;
    else if (!m_busy) begin
      if (mi) begin
        m_busy = 1'b1; m_base = ma & 16'hFFF0; m_off = int'(ma[3:1]); m_iss = 0; m_rcv = 0;
      end
    end else begin
      if (en_x) m_iss++;
      if (wr_x) m_rcv++;
      if (tag_x) m_busy = 1'b0;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drain();
    int k = 0;
    while ((m_busy || ret_q.size() > 0) && k < 60) begin
      cycle(1'b0, 16'($urandom), 1'b0);
      k++;
    end
    chk("drain_timeout", m_busy || ret_q.size() > 0, 0);
  endtask

  initial begin
    int n, f;
    bit ri, mi;
    for (int c = 0; c < 15; c++) begin
      tv[c].miss  = c == 0;
      tv[c].valid = c >= 5 && c <= 12;
      tv[c].busy  = c >= 1 && c <= 12;
      tv[c].en    = c >= 1 && c <= 8;
      tv[c].addr  = tv[c].en ? 16'h1230 + 16'(2 * ord(c - 1, 2)) : 16'h0;
      tv[c].wr    = tv[c].valid;
      tv[c].idx   = tv[c].wr ? ord(c - 5, 2) : 3'd0;
      tv[c].tag   = c == 12;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", fsm_busy, 0);
    chk("rst_en", mem_en, 0);
    chk("rst_addr", memory_address, 0);
    chk("rst_wr", write_data_array, 0);
    chk("rst_idx", fill_word_idx, 0);
    chk("rst_tag", write_tag_array, 0);
    rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      miss_detected = tv[c].miss; miss_address = 16'h1234;
      memory_data_valid = tv[c].valid; memory_data_out = 16'hD000 + 16'(c);
      @(negedge clk);
      chk("t_busy", fsm_busy, tv[c].busy);
      chk("t_en", mem_en, tv[c].en);
      chk("t_addr", memory_address, tv[c].addr);
      chk("t_wr", write_data_array, tv[c].wr);
      chk("t_idx", fill_word_idx, tv[c].idx);
      chk("t_tag", write_tag_array, tv[c].tag);
      chk("t_data", fill_data, 16'hD000 + 16'(c));
      @(posedge clk); #1;
    end
    // top-of-address-space block
    clear();
    cycle(1'b1, 16'hFFFE, 1'b0);
    drain();
    chk("ffe_writes", wr_cyc.size(), 8);
    chk("ffe_tags", tag_cyc.size(), 1);
    chk("ffe_first", en_adr.size() > 0 ? en_adr[0] : 16'hxxxx, CWF ? 16'hFFFE : 16'hFFF0);
    chk("ffe_last", en_adr.size() > 0 ? en_adr[$] : 16'hxxxx, CWF ? 16'hFFFC : 16'hFFFE);
    // reset in the middle of a fill
    clear();
    cycle(1'b1, 16'h1234, 1'b0);
    repeat (5) cycle(1'b0, 16'h1234, 1'b0);
    cycle(1'b0, 16'h1234, 1'b1);
    drain();
    n = 0;
    foreach (wr_cyc[i]) if (wr_cyc[i] >= 7) n++;
    chk("rst_late_wr", n, 0);
    chk("rst_early_wr", wr_cyc.size(), 2);
    chk("rst_tags", tag_cyc.size(), 0);
    // miss held through the fill and one cycle beyond
    clear();
    while (!(tag_cyc.size() > 0 && cyc > tag_cyc[0] + 1) && cyc < 40) cycle(1'b1, 16'h4010, 1'b0);
    drain();
    chk("held_tag1", tag_cyc.size() > 0 ? tag_cyc[0] : -1, 12);
    n = 0; f = -1;
    foreach (en_cyc[i]) begin
      if (en_cyc[i] <= 12) n++;
      else if (f < 0) f = en_cyc[i];
    end
    chk("held_first_reqs", n, 8);
    chk("held_second_en", f, 14);
    chk("held_tags", tag_cyc.size(), 2);
    chk("held_writes", wr_cyc.size(), 16);
`ifdef CRITICAL_WORD_FIRST_EN
    clear();
    cycle(1'b1, 16'h200A, 1'b0);
    drain();
    chk("cwf_reqs", en_adr.size(), 8);
    chk("cwf_writes", wr_idx.size(), 8);
    if (en_adr.size() == 8 && wr_idx.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("cwf_addr", en_adr[i], cwf_a[i]);
        chk("cwf_idx", wr_idx[i], cwf_i[i]);
      end
      chk("cwf_tag_last", tag_cyc.size() == 1 ? tag_cyc[0] : -1, wr_cyc[7]);
    end
`endif
    // randomized traffic with variable latency, stray valids and occasional reset
    clear();
    lat_lo = 1; lat_hi = 6; spur = 1'b1;
    repeat (3000) begin
      ri = $urandom_range(0, 99) == 0;
      mi = !m_busy ? (ret_q.size() == 0 && $urandom_range(0, 2) == 0) : $urandom_range(0, 1) == 1;
      cycle(mi, 16'($urandom), ri);
    end
    drain();
    chk("rand_fills_seen", tag_cyc.size() > 20, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
